// File: rtl/input_keypad_pkg.sv
// Shared keypad types: key-code width, classification and FSM encodings,
// the key-code-to-function map, and snapshot decode helpers.
package input_keypad_pkg;

  localparam int IK_N  = 4;
  localparam int NKEYS = 16;

  // Key-code-to-function map used by the calculator core
  localparam logic [IK_N-1:0] KEY_ADD = 4'd10;
  localparam logic [IK_N-1:0] KEY_SUB = 4'd11;
  localparam logic [IK_N-1:0] KEY_MUL = 4'd12;
  localparam logic [IK_N-1:0] KEY_DIV = 4'd13;
  localparam logic [IK_N-1:0] KEY_EQ  = 4'd14;
  localparam logic [IK_N-1:0] KEY_CLR = 4'd15;

  typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} key_cls_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DEB_P, ST_HELD, ST_DEB_R} kp_state_e;

  function automatic key_cls_e classify(input logic [NKEYS-1:0] s);
    if (s == '0)               return CLS_NONE;
    else if ($countones(s) == 1) return CLS_SINGLE;
    else                       return CLS_MULTI;
  endfunction

  // Index of the lowest set bit; only meaningful when exactly one bit is set
  function automatic logic [IK_N-1:0] key_index(input logic [NKEYS-1:0] s);
    logic [IK_N-1:0] idx;
    idx = '0;
    for (int i = NKEYS-1; i >= 0; i--)
      if (s[i]) idx = IK_N'(i);
    return idx;
  endfunction

endpackage

// File: rtl/input_keypad_if.sv
// Key-code handoff between keypad (master) and calculator core (slave).
interface input_keypad_if;
  import input_keypad_pkg::*;

  logic [IK_N-1:0] key_code;
  logic            key_valid;
  logic            key_ack;
  logic            overrun;

  modport master (output key_code, output key_valid, output overrun, input  key_ack);
  modport slave  (input  key_code, input  key_valid, input  overrun, output key_ack);
endinterface

// File: rtl/input_keypad_scan.sv
// Row scanner: drives one row low per slot, samples columns at the end of
// each slot into a 16-bit snapshot, and classifies it once a full scan ends.
module input_keypad_scan
  import input_keypad_pkg::*;
#(
  parameter int SCAN_DIV = 12500
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [3:0]      KC,
  output logic [3:0]      KR,
  output logic            scan_done,
  output key_cls_e        cls,
  output logic [IK_N-1:0] code
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       row;
  logic [NKEYS-1:0] snapshot;

  // Divider, row advance and end-of-slot column sampling
  always_ff @(posedge Clock) begin
    if (Reset) begin
      div       <= '0;
      row       <= '0;
      snapshot  <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (div == DIV_LAST) begin
        div                       <= '0;
        row                       <= row + 2'd1;
        snapshot[{row, 2'b00} +: 4] <= ~KC;
        scan_done                 <= (row == 2'd3);
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  assign KR = ~(4'b0001 << row);

  // Snapshot decode; only consumed while scan_done is high
  always_comb begin
    cls  = classify(snapshot);
    code = key_index(snapshot);
  end

endmodule

// File: rtl/input_keypad.sv
// Keypad top: scanner, press/release debounce FSM, and the valid/ack
// handoff register with sticky overrun.
module input_keypad
  import input_keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 12500,
  parameter int DEB_SCANS = 10
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [3:0]    KC,
  output logic [3:0]    KR,
  input_keypad_if.master kp
);

  localparam int CNT_W = $clog2(DEB_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            scan_done;
  key_cls_e        cls;
  logic [IK_N-1:0] code;

  kp_state_e       state, state_nx;
  logic [IK_N-1:0] cand, cand_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic            accept;

  logic [IK_N-1:0] code_q;
  logic            valid_q, ovr_q;
  logic            ack_eff;

  input_keypad_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
    .Clock     (Clock),
    .Reset     (Reset),
    .KC        (KC),
    .KR        (KR),
    .scan_done (scan_done),
    .cls       (cls),
    .code      (code)
  );

  // Debounce state register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= ST_IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      cnt   <= cnt_nx;
    end
  end

  // Debounce next-state; decisions only on a completed scan
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    accept   = 1'b0;
    if (scan_done) begin
      unique case (state)
        ST_IDLE: if (cls == CLS_SINGLE) begin
          cand_nx = code;
          cnt_nx  = CNT_ONE;
          if (CNT_MAX == CNT_ONE) begin
            accept   = 1'b1;
            state_nx = ST_HELD;
          end else begin
            state_nx = ST_DEB_P;
          end
        end
        ST_DEB_P: begin
          if (cls != CLS_SINGLE) begin
            state_nx = ST_IDLE;
          end else if (code != cand) begin
            cand_nx = code;
            cnt_nx  = CNT_ONE;
          end else if (cnt + 1'b1 == CNT_MAX) begin
            cnt_nx   = CNT_MAX;
            accept   = 1'b1;
            state_nx = ST_HELD;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        ST_HELD: if (cls == CLS_NONE) begin
          cnt_nx   = CNT_ONE;
          state_nx = (CNT_MAX == CNT_ONE) ? ST_IDLE : ST_DEB_R;
        end
        ST_DEB_R: begin
          if (cls != CLS_NONE) begin
            state_nx = ST_HELD;
          end else if (cnt + 1'b1 == CNT_MAX) begin
            cnt_nx   = CNT_MAX;
            state_nx = ST_IDLE;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  assign ack_eff = kp.key_ack && valid_q;

  // Handoff register: an ack in the accept cycle frees the slot for the new code
  always_ff @(posedge Clock) begin
    if (Reset) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (accept && (!valid_q || kp.key_ack)) begin
        code_q  <= code;
        valid_q <= 1'b1;
      end else if (ack_eff) begin
        valid_q <= 1'b0;
      end
      if (accept && valid_q && !kp.key_ack) ovr_q <= 1'b1;
      else if (ack_eff)                     ovr_q <= 1'b0;
    end
  end

  assign kp.key_code  = code_q;
  assign kp.key_valid = valid_q;
  assign kp.overrun   = ovr_q;

endmodule

// File: tb/tb_input_keypad.sv
// Directed bench for input_keypad with a resistive 4x4 matrix model.
// One scan = 16 cycles; table steps are aligned so each step covers exactly one scan.
module tb_input_keypad;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [3:0]  KC;
  logic [3:0]  KR;
  logic [15:0] keys = '0;

  input_keypad_if kif();

  input_keypad #(.SCAN_DIV(4), .DEB_SCANS(3)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .KC    (KC),
    .KR    (KR),
    .kp    (kif)
  );

  always #5 Clock = ~Clock;

  // Matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    KC = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !KR[r]) KC[c] = 1'b0;
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] keys;
    logic        ack;
    logic        ev;
    logic [3:0]  ec;
    logic        eo;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic ev, input logic [3:0] ec, input logic eo);
    chk({nm, ".valid"},   {15'd0, kif.key_valid}, {15'd0, ev});
    chk({nm, ".code"},    {12'd0, kif.key_code},  {12'd0, ec});
    chk({nm, ".overrun"}, {15'd0, kif.overrun},   {15'd0, eo});
  endtask

  // Assert reset for one edge, check reset values, leave in cycle 0
  task automatic do_reset(input string nm);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk_out(nm, 1'b0, 4'd0, 1'b0);
    chk({nm, ".KR"}, {12'd0, KR}, 16'h000E);
    Reset = 1'b0;
  endtask

  // One scan: enter at cycle 16k+1, leave at 16k+17 with the scan result applied
  task automatic step(input logic [15:0] k, input logic ack);
    keys = k;
    kif.key_ack = ack;
    @(posedge Clock); #1;
    kif.key_ack = 1'b0;
    repeat (15) @(posedge Clock);
    #1;
  endtask

  function automatic void add(input logic [15:0] k, input logic a, input logic ev,
                              input logic [3:0] ec, input logic eo);
    vec_t v;
    v.keys = k; v.ack = a; v.ev = ev; v.ec = ec; v.eo = eo;
    tbl.push_back(v);
  endfunction

  // Key held through reset must come back exactly 49 cycles later
  task automatic emit_after_reset(input string nm, input logic [3:0] ec);
    repeat (48) @(posedge Clock);
    #1;
    chk({nm, ".early"}, {15'd0, kif.key_valid}, 16'd0);
    @(posedge Clock); #1;
    chk_out(nm, 1'b1, ec, 1'b0);
  endtask

  initial begin
    logic [3:0] kr_exp [5];
    logic       idle_bad;
    kif.key_ack = 1'b0;
    kr_exp[0] = 4'b1110; kr_exp[1] = 4'b1101; kr_exp[2] = 4'b1011;
    kr_exp[3] = 4'b0111; kr_exp[4] = 4'b1110;

    // 1: reset, row rotation, idle
    @(posedge Clock); #1;
    do_reset("rst0");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("kr%0d", i), {12'd0, KR}, {12'd0, kr_exp[i]});
      repeat (4) @(posedge Clock);
      #1;
    end
    idle_bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (kif.key_valid !== 1'b0) idle_bad = 1'b1;
      @(posedge Clock); #1;
    end
    chk("idle200", {15'd0, idle_bad}, 16'd0);

    // Table: tests 2..5, one row per scan
    // 2: key 9 held, ack, release
    add(16'h0200,0,0,0,0); add(16'h0200,0,0,0,0); add(16'h0200,0,1,9,0);
    add(16'h0200,1,0,9,0); add(16'h0200,0,0,9,0);
    add(16'h0000,0,0,9,0); add(16'h0000,0,0,9,0); add(16'h0000,0,0,9,0);
    // 3: key 5 bouncing then steady
    add(16'h0020,0,0,9,0); add(16'h0000,0,0,9,0); add(16'h0020,0,0,9,0);
    add(16'h0000,0,0,9,0); add(16'h0020,0,0,9,0); add(16'h0000,0,0,9,0);
    add(16'h0020,0,0,9,0); add(16'h0020,0,0,9,0); add(16'h0020,0,1,5,0);
    add(16'h0000,1,0,5,0); add(16'h0000,0,0,5,0); add(16'h0000,0,0,5,0);
    // 4: keys 3+7 together, then 7 released
    add(16'h0088,0,0,5,0); add(16'h0088,0,0,5,0); add(16'h0088,0,0,5,0);
    add(16'h0088,0,0,5,0);
    add(16'h0008,0,0,5,0); add(16'h0008,0,0,5,0); add(16'h0008,0,1,3,0);
    add(16'h0008,1,0,3,0);
    add(16'h0000,0,0,3,0); add(16'h0000,0,0,3,0); add(16'h0000,0,0,3,0);
    // 5: press 1 unacked, press 2 overruns, ack, press 4
    add(16'h0002,0,0,3,0); add(16'h0002,0,0,3,0); add(16'h0002,0,1,1,0);
    add(16'h0000,0,1,1,0); add(16'h0000,0,1,1,0); add(16'h0000,0,1,1,0);
    add(16'h0004,0,1,1,0); add(16'h0004,0,1,1,0); add(16'h0004,0,1,1,1);
    add(16'h0004,1,0,1,0);
    add(16'h0000,0,0,1,0); add(16'h0000,0,0,1,0); add(16'h0000,0,0,1,0);
    add(16'h0010,0,0,1,0); add(16'h0010,0,0,1,0); add(16'h0010,0,1,4,0);
    add(16'h0000,1,0,4,0); add(16'h0000,0,0,4,0); add(16'h0000,0,0,4,0);

    do_reset("rst1");
    @(posedge Clock); #1;
    foreach (tbl[i]) begin
      step(tbl[i].keys, tbl[i].ack);
      chk_out($sformatf("v%0d", i + 1), tbl[i].ev, tbl[i].ec, tbl[i].eo);
      chk($sformatf("v%0d.KR", i + 1), {12'd0, KR}, 16'h000E);
    end

    // 6a: reset mid-DEB_P, key 6 held through it
    step(16'h0040, 1'b0); step(16'h0040, 1'b0);
    chk_out("debp", 1'b0, 4'd4, 1'b0);
    do_reset("rst_debp");
    emit_after_reset("re6", 4'd6);

    // 6b: build up valid=1 + overrun=1 in HELD, then reset
    step(16'h0000, 1'b0); step(16'h0000, 1'b0); step(16'h0000, 1'b0);
    chk_out("rel6", 1'b1, 4'd6, 1'b0);
    step(16'h0100, 1'b0); step(16'h0100, 1'b0); step(16'h0100, 1'b0);
    chk_out("ovr8", 1'b1, 4'd6, 1'b1);
    do_reset("rst_held");
    emit_after_reset("re8", 4'd8);
    step(16'h0100, 1'b0); step(16'h0100, 1'b0); step(16'h0100, 1'b0);
    chk_out("hold8", 1'b1, 4'd8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
